// File: rtl/branch_client_pkg.sv
// Shared types and constants for the branch client slice.
package branch_client_pkg;

  // Default width of the hit/miss statistics counters.
  localparam int CNT_W_DEF = 8;

  // Transaction FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_SAMPLE   = 3'd2,
    ST_WAIT_OUT = 3'd3,
    ST_RESOLVE  = 3'd4
  } state_e;

endpackage

// File: rtl/branch_client_if.sv
// Handshake bundle between branch_client, the predictor and the execute stream.
interface branch_client_if;
  logic start;
  logic outcome_valid;
  logic outcome_taken;
  logic prediction;
  logic request;
  logic result;
  logic taken;

  modport master (
    input  start, outcome_valid, outcome_taken, prediction,
    output request, result, taken
  );

  modport slave (
    output start, outcome_valid, outcome_taken, prediction,
    input  request, result, taken
  );
endinterface

// File: rtl/branch_client_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter
  import branch_client_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count enabled increments, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/branch_client.sv
// Branch client: requests a prediction, pairs it with the actual outcome,
// reports the resolution to the predictor and keeps hit/miss statistics.
module branch_client
  import branch_client_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_client_if.master  bus,
  output logic             busy,
  output logic             pred_valid,
  output logic             pred_q,
  output logic             mispredict,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_e state_r;
  logic   ready_r;      // low for the first edge after reset release
  logic   request_r;
  logic   result_r;
  logic   taken_r;
  logic   busy_r;
  logic   pred_valid_r;
  logic   pred_q_r;
  logic   mispredict_r;
  logic   lat_valid_r;  // one-entry outcome buffer, first outcome wins
  logic   lat_taken_r;

  logic   go_s;
  logic   dir_s;
  logic   hit_inc_s;
  logic   miss_inc_s;

  // In SAMPLE the buffered outcome takes priority over a live one.
  assign go_s  = lat_valid_r | bus.outcome_valid;
  assign dir_s = lat_valid_r ? lat_taken_r : bus.outcome_taken;

  // Transaction FSM with registered strobes; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b0;
      request_r    <= 1'b0;
      result_r     <= 1'b0;
      taken_r      <= 1'b0;
      busy_r       <= 1'b0;
      pred_valid_r <= 1'b0;
      pred_q_r     <= 1'b0;
      mispredict_r <= 1'b0;
      lat_valid_r  <= 1'b0;
      lat_taken_r  <= 1'b0;
    end else begin
      ready_r      <= 1'b1;
      request_r    <= 1'b0;
      result_r     <= 1'b0;
      taken_r      <= 1'b0;
      pred_valid_r <= 1'b0;
      mispredict_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && ready_r) begin
            state_r   <= ST_REQ;
            request_r <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        ST_REQ: begin
          state_r <= ST_SAMPLE;
          if (bus.outcome_valid) begin
            lat_valid_r <= 1'b1;
            lat_taken_r <= bus.outcome_taken;
          end
        end
        ST_SAMPLE: begin
          pred_q_r     <= bus.prediction;
          pred_valid_r <= 1'b1;
          if (go_s) begin
            state_r      <= ST_RESOLVE;
            result_r     <= 1'b1;
            taken_r      <= dir_s;
            mispredict_r <= bus.prediction ^ dir_s;
            lat_valid_r  <= 1'b0;
          end else begin
            state_r <= ST_WAIT_OUT;
          end
        end
        ST_WAIT_OUT: begin
          if (bus.outcome_valid) begin
            state_r      <= ST_RESOLVE;
            result_r     <= 1'b1;
            taken_r      <= bus.outcome_taken;
            mispredict_r <= pred_q_r ^ bus.outcome_taken;
          end
        end
        ST_RESOLVE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          lat_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Statistics update on the edge leaving RESOLVE.
  assign hit_inc_s  = (state_r == ST_RESOLVE) && (pred_q_r == taken_r);
  assign miss_inc_s = (state_r == ST_RESOLVE) && (pred_q_r != taken_r);

  sat_counter #(.CNT_W(CNT_W)) u_hit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc_s),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc_s),
    .count (miss_count)
  );

  assign bus.request = request_r;
  assign bus.result  = result_r;
  assign bus.taken   = taken_r;
  assign busy        = busy_r;
  assign pred_valid  = pred_valid_r;
  assign pred_q      = pred_q_r;
  assign mispredict  = mispredict_r;

endmodule

// File: tb/tb_branch_client.sv
// Directed bench: branch_client paired with a 2-bit predictor model.
module tb_branch_client;

  logic clk = 1'b0;
  logic rst_n;
  logic start, ov, ot;
  logic [1:0] ctr;
  int n_assert = 0;
  int n_fail   = 0;

  logic       busy1, pv1, pq1, mis1;
  logic [7:0] hit1, miss1;
  logic       busy2, pv2, pq2, mis2;
  logic [1:0] hit2, miss2;

  branch_client_if bif1 ();
  branch_client_if bif2 ();

  assign bif1.start = start;  assign bif2.start = start;
  assign bif1.outcome_valid = ov;  assign bif2.outcome_valid = ov;
  assign bif1.outcome_taken = ot;  assign bif2.outcome_taken = ot;
  assign bif1.prediction = ctr[1];  assign bif2.prediction = ctr[1];

  branch_client #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif1.master), .busy(busy1), .pred_valid(pv1),
    .pred_q(pq1), .mispredict(mis1), .hit_count(hit1), .miss_count(miss1));

  branch_client #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bif2.master), .busy(busy2), .pred_valid(pv2),
    .pred_q(pq2), .mispredict(mis2), .hit_count(hit2), .miss_count(miss2));

  always #5 clk = ~clk;

  // 2-bit saturating predictor, reset to strongly-taken, trained on result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr <= 2'd3;
    else if (bif1.result) begin
      if (bif1.taken && ctr != 2'd3) ctr <= ctr + 2'd1;
      else if (!bif1.taken && ctr != 2'd0) ctr <= ctr - 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction with the outcome presented in SAMPLE.
  task automatic run_txn(input logic tk, input logic exp_pred, input logic exp_mis);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("req_cycle1", {30'd0, bif1.request, busy1}, 32'd3);
    @(negedge clk);
    chk("sample_quiet", {30'd0, bif1.request, bif1.result}, 32'd0);
    ov = 1'b1; ot = tk;
    @(negedge clk); ov = 1'b0; ot = 1'b0;
    chk("result_cycle3", {31'd0, bif1.result}, 32'd1);
    chk("taken", {31'd0, bif1.taken}, {31'd0, tk});
    chk("pred_q", {30'd0, pv1, pq1}, {30'd0, 1'b1, exp_pred});
    chk("mispredict", {31'd0, mis1}, {31'd0, exp_mis});
    @(negedge clk);
    chk("idle_after", {29'd0, busy1, bif1.result, bif1.taken}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ov = 1'b0; ot = 1'b0;
    #3;
    chk("reset_outs", {25'd0, bif1.request, bif1.result, bif1.taken, busy1, pv1, pq1, mis1}, 32'd0);
    chk("reset_cnts", {16'd0, hit1, miss1}, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Taken outcome with strongly-taken predictor: hit.
    run_txn(1'b1, 1'b1, 1'b0);
    chk("t1_counts", {16'd0, hit1, miss1}, {16'd0, 8'd1, 8'd0});
    // Three not-taken: predictions 1,1,0.
    run_txn(1'b0, 1'b1, 1'b1);
    run_txn(1'b0, 1'b1, 1'b1);
    run_txn(1'b0, 1'b0, 1'b0);
    chk("t4_counts", {16'd0, hit1, miss1}, {16'd0, 8'd2, 8'd2});

    // Outcome withheld 10 cycles: WAIT_OUT holds.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("wait_hold", {30'd0, busy1, bif1.result}, 32'd2);
    end
    ov = 1'b1; ot = 1'b0;
    @(negedge clk); ov = 1'b0;
    chk("wait_result", {30'd0, bif1.result, mis1}, 32'd2);
    @(negedge clk);
    chk("wait_counts", {16'd0, hit1, miss1}, {16'd0, 8'd3, 8'd2});

    // Outcome in REQ (not-taken) then SAMPLE (taken): first wins.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    ov = 1'b1; ot = 1'b0;
    @(negedge clk);
    ov = 1'b1; ot = 1'b1;
    @(negedge clk); ov = 1'b0; ot = 1'b0;
    chk("first_wins", {30'd0, bif1.result, bif1.taken}, 32'd2);
    @(negedge clk);
    chk("fw_counts", {16'd0, hit1, miss1}, {16'd0, 8'd4, 8'd2});

    // Reset during WAIT_OUT.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {25'd0, bif1.request, bif1.result, bif1.taken, busy1, pv1, pq1, mis1}, 32'd0);
    chk("midrst_cnts", {16'd0, hit1, miss1}, 32'd0);
    @(negedge clk);
    chk("rst_no_result", {31'd0, bif1.result}, 32'd0);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("first_edge_ignored", {31'd0, busy1}, 32'd0);

    // Five hits: narrow counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      run_txn(1'b1, 1'b1, 1'b0);
      chk("hits_w8", {24'd0, hit1}, k);
      chk("hits_w2", {30'd0, hit2}, (k > 3) ? 32'd3 : k);
    end
    chk("miss_w2", {30'd0, miss2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
